// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// Handshake: a byte moves on a rising clk edge where byte_valid && byte_ready;
// byte_in is a don't-care otherwise, and the source may drop byte_valid at any time.
interface prog_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [11:0] load_I;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, load_en, load_addr, load_I
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, load_en, load_addr, load_I
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses a count/instruction/checksum byte frame and writes
// 12-bit words to program memory, enabling the CPU only on a verified image.
module prog_loader (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  prog_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_en,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  left_q;      // instructions still to be written in this frame
  logic [7:0]  addr_q;      // address of the next write
  logic [7:0]  cks_q;
  logic [3:0]  hi_q;
  logic        load_en_q;
  logic [7:0]  load_addr_q;
  logic [11:0] load_I_q;
  logic        accept;

  assign accept    = bus.byte_valid && bus.byte_ready;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.byte_ready = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_COUNT;
      S_COUNT: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (accept) state_d = S_HI;
      end
      S_HI: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (accept) state_d = (bus.byte_in[7:4] != 4'h0) ? S_ERR : S_LO;
      end
      S_LO: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (accept) state_d = (left_q == 9'd1) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (accept) state_d = (bus.byte_in == cks_q) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_COUNT;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_d = S_COUNT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cpu_en = done;

  // Datapath: address, remaining count, checksum and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q      <= 9'd0;
      addr_q      <= 8'd0;
      cks_q       <= 8'd0;
      hi_q        <= 4'd0;
      load_en_q   <= 1'b0;
      load_addr_q <= 8'd0;
      load_I_q    <= 12'd0;
    end else begin
      load_en_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_COUNT: begin
            left_q <= (bus.byte_in == 8'd0) ? 9'd256 : {1'b0, bus.byte_in};
            addr_q <= 8'd0;
            cks_q  <= bus.byte_in;
          end
          S_HI: begin
            if (bus.byte_in[7:4] == 4'h0) begin
              hi_q  <= bus.byte_in[3:0];
              cks_q <= cks_q ^ bus.byte_in;
            end
          end
          S_LO: begin
            cks_q       <= cks_q ^ bus.byte_in;
            load_en_q   <= 1'b1;
            load_addr_q <= addr_q;
            load_I_q    <= {hi_q, bus.byte_in};
            addr_q      <= addr_q + 8'd1;
            left_q      <= left_q - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.load_en   = load_en_q;
  assign bus.load_addr = load_addr_q;
  assign bus.load_I    = load_I_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame-level bench for prog_loader: a frame model predicts the
// write list and verdict, and a negedge monitor checks every cycle against it.
module tb_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done, err, cpu_en;
  logic [2:0] state_dbg;
  int         cyc;
  int         vectors;
  int         miscompares;

  prog_loader_if bus ();

  prog_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_en    (cpu_en),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];      // {addr, instruction}
  int          exp_cyc_q[$];  // negedge cycle index where each write must be visible
  logic [19:0] act_log[$];
  logic [19:0] last_wr;
  logic [7:0]  frame[$];
  logic [19:0] model_wr[$];
  int          model_consumed;
  bit          model_done;
  logic [7:0]  model_cks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: whole-frame interpretation ----------------
  task automatic run_model();
    int total;
    logic [7:0] hi, lo;
    model_wr.delete();
    total      = (frame[0] == 8'd0) ? 256 : int'(frame[0]);
    model_cks  = frame[0];
    model_done = 1'b0;
    for (int i = 0; i < total; i++) begin
      hi = frame[1 + 2*i];
      if (hi[7:4] != 4'h0) begin
        model_consumed = 2 + 2*i;
        return;
      end
      lo = frame[2 + 2*i];
      model_cks = model_cks ^ hi ^ lo;
      model_wr.push_back({8'(i), hi[3:0], lo});
    end
    model_consumed = 2 + 2*total;
    model_done     = (frame[1 + 2*total] == model_cks);
  endtask

  task automatic make_frame(input logic [7:0] n8, input bit bad_cks, input int bad_idx);
    int total;
    logic [7:0] hi, lo, x;
    frame.delete();
    frame.push_back(n8);
    total = (n8 == 8'd0) ? 256 : int'(n8);
    x = n8;
    for (int i = 0; i < total; i++) begin
      hi = {4'h0, 4'($urandom)};
      if (i == bad_idx) hi[7:4] = 4'($urandom_range(1, 15));
      lo = 8'($urandom);
      x  = x ^ hi ^ lo;
      frame.push_back(hi);
      frame.push_back(lo);
    end
    frame.push_back(bad_cks ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_err_clr", 32'(err), 32'd0);
    chk("start_cpu_en_clr", 32'(cpu_en), 32'd0);
  endtask

  task automatic drive(input int n, input int gap);
    int i = 0;
    int guard = 0;
    while (i < n) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        chk("drive_timeout", 32'(i), 32'(n));
        break;
      end
      bus.byte_valid = ($urandom_range(99) >= gap);
      bus.byte_in    = bus.byte_valid ? frame[i] : 8'($urandom);
      start          = (i > 0) && ($urandom_range(15) == 0);
      if (bus.byte_valid && bus.byte_ready) begin
        if (i >= 2 && (i % 2) == 0 && (i - 2) / 2 < model_wr.size()) begin
          exp_q.push_back(model_wr[(i - 2) / 2]);
          exp_cyc_q.push_back(cyc + 1);
        end
        i++;
      end
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start          = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_done"}, 32'(done), 32'(model_done));
    chk({tag, "_err"}, 32'(err), 32'(!model_done));
    chk({tag, "_cpu_en"}, 32'(cpu_en), 32'(model_done));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_frame(input string tag, input int gap);
    run_model();
    act_log.delete();
    pulse_start();
    drive(model_consumed, gap);
    check_status(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_load_en"}, 32'(bus.load_en), 32'd0);
    chk({tag, "_addr"}, 32'(bus.load_addr), 32'd0);
    chk({tag, "_I"}, 32'(bus.load_I), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      last_wr = 20'd0;
    end else begin
      chk("cpu_en_eq_done", 32'(cpu_en), 32'(done));
      chk("busy_eq_ready", 32'(busy), 32'(bus.byte_ready));
      if (bus.load_en) begin
        act_log.push_back({bus.load_addr, bus.load_I});
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'({bus.load_addr, bus.load_I}), 32'hFFFFFFFF);
        end else begin
          chk("write_cycle", 32'(cyc), 32'(exp_cyc_q[0]));
          chk("write_addr", 32'(bus.load_addr), 32'(exp_q[0][19:12]));
          chk("write_data", 32'(bus.load_I), 32'(exp_q[0][11:0]));
          last_wr = exp_q[0];
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end else begin
        chk("hold_addr", 32'(bus.load_addr), 32'(last_wr[19:12]));
        chk("hold_I", 32'(bus.load_I), 32'(last_wr[11:0]));
        if (exp_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
          chk("missing_write", 32'd0, 32'(exp_q[0]));
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'd0;
    last_wr        = 20'd0;
    #1;
    check_zero("in_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_zero("post_reset");
    end

    // Nominal two-instruction image with literal expectations.
    frame = '{8'h02, 8'h0A, 8'hBC, 8'h03, 8'h21, 8'h96};
    do_frame("nominal", 0);
    chk("model_cks_lit", 32'(model_cks), 32'h96);
    chk("nom_writes", 32'(act_log.size()), 32'd2);
    if (act_log.size() == 2) begin
      chk("nom_w0", 32'(act_log[0]), 32'h00ABC);
      chk("nom_w1", 32'(act_log[1]), 32'h01321);
    end
    chk("nom_done_lit", 32'(done), 32'd1);

    // Bad checksum, then recovery with a good frame.
    frame = '{8'h02, 8'h0A, 8'hBC, 8'h03, 8'h21, 8'h97};
    do_frame("bad_cks", 0);
    chk("bad_cks_writes", 32'(act_log.size()), 32'd2);
    chk("bad_cks_err_lit", 32'(err), 32'd1);
    frame = '{8'h02, 8'h0A, 8'hBC, 8'h03, 8'h21, 8'h96};
    do_frame("recover", 20);

    // Bad high nibble on the first instruction.
    frame = '{8'h01, 8'h1F, 8'h00, 8'h1F};
    do_frame("bad_hi", 0);
    chk("bad_hi_writes", 32'(act_log.size()), 32'd0);
    chk("bad_hi_err_lit", 32'(err), 32'd1);

    // Full 256-word images, streaming and with random gaps.
    make_frame(8'h00, 1'b0, -1);
    do_frame("full_stream", 0);
    chk("full_stream_writes", 32'(act_log.size()), 32'd256);
    if (act_log.size() == 256) chk("full_last_addr", 32'(act_log[255][19:12]), 32'hFF);
    make_frame(8'h00, 1'b0, -1);
    do_frame("full_gaps", 35);
    chk("full_gaps_writes", 32'(act_log.size()), 32'd256);

    // Random frames: mixed sizes, corrupted checksums and bad high bytes.
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(1, 24);
      make_frame(8'(n), ($urandom_range(3) == 0),
                 ($urandom_range(3) == 0) ? int'($urandom_range(0, n - 1)) : -1);
      do_frame("random", $urandom_range(0, 50));
    end

    // Abort: reset after the third write, with a start pulse while busy first.
    make_frame(8'd10, 1'b0, -1);
    run_model();
    pulse_start();
    drive(8, 25);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_still_busy", 32'(busy), 32'd1);
    chk("abort_no_done", 32'(done), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("abort_reset");
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_zero("abort_idle");
    end

    // Loader must still accept a full frame after the abort.
    make_frame(8'd5, 1'b0, -1);
    do_frame("after_abort", 10);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time loader that drives the write port of the 256 x 12-bit program memory from an external byte stream. It accepts a framed image over a valid/ready byte interface: a count byte, two bytes per instruction, then an XOR checksum byte. It assembles each 12-bit instruction and issues one write per instruction at sequential addresses from 0. It asserts the memory/CPU enable only after a complete, checksum-verified image is loaded.

## Interface
- No parameters; widths are fixed at 8-bit address, 12-bit instruction, and 8-bit byte.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a new load; honored only in IDLE, DONE or ERR.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle.
- load_en  output  1  program-memory write strobe, one cycle per instruction.
- load_addr  output  8  program-memory write address.
- load_I  output  12  instruction written.
- busy  output  1  a frame is in progress.
- done  output  1  image loaded and verified.
- err  output  1  frame rejected.
- cpu_en  output  1  drives the program-memory E input; equals done.

## Operation
- Handshake: a byte is consumed on a rising edge where byte_valid && byte_ready. byte_in is ignored otherwise.
- States and transitions:
  - IDLE: start -> COUNT.
  - COUNT: accept the count byte N. Instruction total = N, except N = 0 means 256. Clear the write address to 0. Seed the checksum with N. -> HI.
  - HI: accept the high byte. If bits [7:4] != 0 -> ERR. Otherwise latch bits [3:0] as instruction [11:8] and XOR the byte into the checksum. -> LO.
  - LO: accept the low byte as instruction [7:0] and XOR it into the checksum. Register a write with load_I = {hi[3:0], byte}. If this was the last instruction -> CHECK, else -> HI.
  - CHECK: accept the checksum byte. If it equals the running XOR -> DONE, else -> ERR.
  - DONE: done = 1 and cpu_en = 1. start -> COUNT.
  - ERR: err = 1. start -> COUNT.
- byte_ready = 1 in COUNT, HI, LO and CHECK. It is 0 in IDLE, DONE and ERR.
- busy = 1 in COUNT, HI, LO and CHECK.
- start is ignored while busy.
- Writes:
  - load_addr is 0 for the first instruction and increments by 1 after each write.
  - With N = 0 the last write is at address 255, and the address does not wrap within a frame.
  - Words already written before an ERR remain in memory; cpu_en stays 0.
- Checksum: an 8-bit XOR over the count byte and all instruction bytes of the frame. The checksum byte itself is excluded.
- Restart from DONE/ERR: done, err and cpu_en clear on the cycle COUNT is entered.

## Timing
- Reset values: state IDLE, all outputs 0 (byte_ready, load_en, load_addr, load_I, busy, done, err, cpu_en). The address counter and checksum are also 0.
- Write latency: load_en is high for exactly one cycle, the cycle after the LO byte is accepted. load_addr and load_I are valid in that same cycle.
- load_addr and load_I hold their values when load_en is 0.
- Back-to-back throughput: one byte per cycle with byte_valid held high. A frame of N instructions completes in 2N+2 accepted bytes.
- The next HI byte may be accepted in the same cycle as the previous instruction's load_en.
- done and cpu_en rise in the cycle after the checksum byte is accepted. err rises in the cycle after the offending byte is accepted.
- Stalls: byte_valid low in any accepting state holds all state. No timeout.
- An rst_n assertion mid-frame returns immediately to IDLE with all outputs 0. Memory contents are not the loader's concern.

## Test plan
- Reset: hold rst_n = 0, then release -> all outputs 0, byte_ready = 0, and no activity without start.
- Nominal load: start, then bytes 02, 0A, BC, 03, 21, checksum 02^0A^BC^03^21 = 96 -> two writes: (addr 00, I ABC) and (addr 01, I 321), each with load_en exactly one cycle. Then done = cpu_en = 1 and busy = 0.
- Bad checksum: same frame with checksum 97 -> both writes occur, then err = 1 and cpu_en = 0. A following start plus a valid frame clears err and ends in done.
- Bad high nibble: start, 01, 1F -> err = 1 the next cycle, no load_en, byte_ready = 0.
- Full image: N = 00, then 256 instructions with byte_valid held high and random byte_valid gaps -> 256 writes at addresses 00..FF with data matching the stream. load_addr never wraps, and done follows the correct checksum.
- Abort: apply rst_n low after the 3rd instruction write, then release -> IDLE with all outputs 0. start while busy mid-frame has no effect on state.
